// File: rtl/key_conditioner.sv
// key_conditioner: turns the raw KEY0 (up) and KEY1 (down) push-buttons into
// clean one-cycle step pulses for the LED dimmer.
// Each key has a two-flop synchroniser, a counter-based debounce, press-edge
// detection and an optional hold-to-repeat.
// Optional feature macro: KEY_REPEAT_EN. When defined, a held key auto-repeats.
// When undefined, each debounced press gives exactly one step pulse.
// When test is 1, every timing limit is divided by 10 for quick bring-up.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic clock_50,
    input  logic clr_n,
    input  logic up_n,
    input  logic down_n,
    input  logic test,
    output logic up_step,
    output logic down_step,
    output logic up_held,
    output logic down_held
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEB_PRESS = 3'd1,
        HOLD      = 3'd2,
        REPEAT    = 3'd3,
        DEB_REL   = 3'd4
    } key_state_t;

    // Limits are one bit wider than the counter, so that count+1 never wraps
    // in a compare.
    logic [CNT_W:0] lim_d;
`ifdef KEY_REPEAT_EN
    logic [CNT_W:0] lim_r;
    logic [CNT_W:0] lim_p;
`endif

    // Select the active limits. test is sampled every cycle.
    always_comb begin
        lim_d = test ? (CNT_W+1)'(DEBOUNCE_CYCLES / 10) : (CNT_W+1)'(DEBOUNCE_CYCLES);
`ifdef KEY_REPEAT_EN
        lim_r = test ? (CNT_W+1)'(REPEAT_DELAY / 10)  : (CNT_W+1)'(REPEAT_DELAY);
        lim_p = test ? (CNT_W+1)'(REPEAT_PERIOD / 10) : (CNT_W+1)'(REPEAT_PERIOD);
`endif
    end

    // Index 0 is the up key and index 1 is the down key.
    logic [1:0] raw_n;
    logic [1:0] pulse_vec;
    logic [1:0] held_vec;

    assign raw_n = {down_n, up_n};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            logic             sync1_reg;
            logic             sync_x_reg;
            key_state_t       state_reg;
            key_state_t       state_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic [CNT_W:0]   cnt_inc;
            logic             held_reg;
            logic             held_next;
            logic             pulse_next;
            logic             pressed;

            assign pressed      = ~sync_x_reg;
            assign cnt_inc      = {1'b0, cnt_reg} + 1'b1;
            assign pulse_vec[gi] = pulse_next;
            assign held_vec[gi]  = held_reg;

            // Two-flop synchroniser. It resets to "released", so after reset
            // a key that is still held is seen as a new press.
            always_ff @(posedge clock_50 or negedge clr_n) begin
                if (!clr_n) begin
                    sync1_reg  <= 1'b1;
                    sync_x_reg <= 1'b1;
                end else begin
                    sync1_reg  <= raw_n[gi];
                    sync_x_reg <= sync1_reg;
                end
            end

            // Registers for the debounce/repeat FSM state, counter and held level.
            always_ff @(posedge clock_50 or negedge clr_n) begin
                if (!clr_n) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    held_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    held_reg  <= held_next;
                end
            end

            // Next-state logic. Compares use >= so that a limit which shrinks
            // below the current count fires on the next cycle.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                held_next  = held_reg;
                pulse_next = 1'b0;
                case (state_reg)
                    IDLE: begin
                        cnt_next  = '0;
                        held_next = 1'b0;
                        if (pressed) state_next = DEB_PRESS;
                    end
                    DEB_PRESS: begin
                        if (!pressed) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else if (cnt_inc >= lim_d) begin
                            state_next = HOLD;
                            held_next  = 1'b1;
                            pulse_next = 1'b1;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_inc[CNT_W-1:0];
                        end
                    end
                    HOLD: begin
                        if (!pressed) begin
                            state_next = DEB_REL;
                            cnt_next   = '0;
`ifdef KEY_REPEAT_EN
                        end else if (cnt_inc >= lim_r) begin
                            state_next = REPEAT;
                            pulse_next = 1'b1;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_inc[CNT_W-1:0];
                        end
`else
                        end else begin
                            cnt_next = '0;
                        end
`endif
                    end
`ifdef KEY_REPEAT_EN
                    REPEAT: begin
                        if (!pressed) begin
                            state_next = DEB_REL;
                            cnt_next   = '0;
                        end else if (cnt_inc >= lim_p) begin
                            pulse_next = 1'b1;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_inc[CNT_W-1:0];
                        end
                    end
`endif
                    DEB_REL: begin
                        // A pressed sample is bounce. Go back to holding
                        // without producing a step.
                        if (pressed) begin
                            state_next = HOLD;
                            cnt_next   = '0;
                        end else if (cnt_inc >= lim_d) begin
                            state_next = IDLE;
                            held_next  = 1'b0;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_inc[CNT_W-1:0];
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        held_next  = 1'b0;
                    end
                endcase
            end
        end
    endgenerate

    // Register the step outputs. Opposing pulses in the same cycle cancel
    // each other out.
    always_ff @(posedge clock_50 or negedge clr_n) begin
        if (!clr_n) begin
            up_step   <= 1'b0;
            down_step <= 1'b0;
        end else begin
            up_step   <= pulse_vec[0] & ~pulse_vec[1];
            down_step <= pulse_vec[1] & ~pulse_vec[0];
        end
    end

    assign up_held   = held_vec[0];
    assign down_held = held_vec[1];

endmodule
